// File: rtl/display_scheduler.sv
// Time-shares one 4-digit hex display among N_SRC requesters: round-robin ownership with a
// minimum hold time and a dark gap between owners. All outputs are registered.
module display_scheduler #(
  parameter int unsigned N_SRC        = 3,
  parameter int unsigned HOLD_CYCLES  = 27_000_000,
  parameter int unsigned BLANK_CYCLES = 270_000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_SRC-1:0]     req,
  input  logic [16*N_SRC-1:0]  data_in,
  output logic [N_SRC-1:0]     grant,
  output logic [15:0]          data_out,
  output logic                 blank_out,
  output logic                 busy
);

  localparam int unsigned SelW   = $clog2(N_SRC);
  localparam int unsigned HoldW  = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned BlankW = $clog2(BLANK_CYCLES + 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBlank = 2'd1,
    StShow  = 2'd2
  } state_e;

  state_e            state_q;
  logic [SelW-1:0]   sel_q;
  logic [SelW-1:0]   last_q;
  logic [HoldW-1:0]  hold_cnt_q;
  logic [BlankW-1:0] blank_cnt_q;
  logic [N_SRC-1:0]  grant_q;
  logic [15:0]       data_q;
  logic              blank_q;
  logic              busy_q;

  logic              win_valid;
  logic [SelW-1:0]   win_idx;
  logic              others_req;
  logic              blank_done;
  logic              hold_done;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      idx = 32'(last_q) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!win_valid && req[idx]) begin
        win_valid = 1'b1;
        win_idx   = SelW'(idx);
      end
    end
  end

  // grant_q is onehot(sel_q) while showing, so masking with it isolates the other sources.
  assign others_req = |(req & ~grant_q);
  assign blank_done = (blank_cnt_q == BlankW'(BLANK_CYCLES - 1));
  assign hold_done  = (hold_cnt_q == HoldW'(HOLD_CYCLES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      last_q      <= SelW'(N_SRC - 1);
      hold_cnt_q  <= '0;
      blank_cnt_q <= '0;
      grant_q     <= '0;
      data_q      <= 16'h0000;
      blank_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            state_q     <= StBlank;
            blank_cnt_q <= '0;
            busy_q      <= 1'b1;
          end
        end
        StBlank: begin
          if (blank_done) begin
            if (win_valid) begin
              state_q    <= StShow;
              sel_q      <= win_idx;
              grant_q    <= N_SRC'(1) << win_idx;
              data_q     <= data_in[16*win_idx +: 16];
              blank_q    <= 1'b0;
              hold_cnt_q <= '0;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end else begin
            blank_cnt_q <= blank_cnt_q + 1'b1;
          end
        end
        StShow: begin
          data_q <= data_in[16*sel_q +: 16];
          if (!req[sel_q]) begin
            grant_q     <= '0;
            blank_q     <= 1'b1;
            last_q      <= sel_q;
            blank_cnt_q <= '0;
            if (others_req) begin
              state_q <= StBlank;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end else if (hold_done && others_req) begin
            state_q     <= StBlank;
            grant_q     <= '0;
            blank_q     <= 1'b1;
            last_q      <= sel_q;
            blank_cnt_q <= '0;
          end else if (!hold_done) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          grant_q <= '0;
          blank_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant     = grant_q;
  assign data_out  = data_q;
  assign blank_out = blank_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler (N_SRC=3, HOLD_CYCLES=8, BLANK_CYCLES=2): a vector
// table for single-request and early-release flows, plus sequences for rotation and resets.
module tb_display_scheduler;

  logic        clk;
  logic        reset_n;
  logic [2:0]  req;
  logic [47:0] data_in;
  logic [2:0]  grant;
  logic [15:0] data_out;
  logic        blank_out;
  logic        busy;

  int n_vec;
  int n_fail;

  display_scheduler #(
    .N_SRC       (3),
    .HOLD_CYCLES (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .data_in  (data_in),
    .grant    (grant),
    .data_out (data_out),
    .blank_out(blank_out),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [2:0]  eg;
    logic        eb;
    logic        ebusy;
    logic [15:0] ed;
  } vec_t;

  vec_t tbl[14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] eg, input logic eb,
                       input logic ebusy, input logic [15:0] ed);
    n_vec++;
    if (grant !== eg || blank_out !== eb || busy !== ebusy || data_out !== ed) begin
      n_fail++;
      $display("FAIL %s: got grant=%b blank=%b busy=%b data=%h, want grant=%b blank=%b busy=%b data=%h",
               name, grant, blank_out, busy, data_out, eg, eb, ebusy, ed);
    end
  endtask

  task automatic do_reset(input logic [2:0] r);
    reset_n = 1'b0;
    req     = r;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [15:0] prev;
    logic [15:0] word;
    logic [1:0]  owner;
    n_vec   = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    req     = 3'b000;
    data_in = '0;

    //               req     d0        d1        grant   blank busy data
    tbl[0]  = '{3'b010, 16'h0000, 16'h12AB, 3'b000, 1'b1, 1'b1, 16'h0000};
    tbl[1]  = '{3'b010, 16'h0000, 16'h12AB, 3'b000, 1'b1, 1'b1, 16'h0000};
    tbl[2]  = '{3'b010, 16'h0000, 16'h12AB, 3'b010, 1'b0, 1'b1, 16'h12AB};
    tbl[3]  = '{3'b010, 16'h0000, 16'h12AB, 3'b010, 1'b0, 1'b1, 16'h12AB};
    tbl[4]  = '{3'b010, 16'h0000, 16'h12AB, 3'b010, 1'b0, 1'b1, 16'h12AB};
    tbl[5]  = '{3'b010, 16'h0000, 16'h0F0F, 3'b010, 1'b0, 1'b1, 16'h0F0F};
    tbl[6]  = '{3'b000, 16'h0000, 16'h0F0F, 3'b000, 1'b1, 1'b0, 16'h0F0F};
    tbl[7]  = '{3'b000, 16'h0000, 16'h0F0F, 3'b000, 1'b1, 1'b0, 16'h0F0F};
    tbl[8]  = '{3'b001, 16'hA5A5, 16'h0F0F, 3'b000, 1'b1, 1'b1, 16'h0F0F};
    tbl[9]  = '{3'b001, 16'hA5A5, 16'h0F0F, 3'b000, 1'b1, 1'b1, 16'h0F0F};
    tbl[10] = '{3'b001, 16'hA5A5, 16'h0F0F, 3'b001, 1'b0, 1'b1, 16'hA5A5};
    tbl[11] = '{3'b001, 16'hA5A5, 16'h0F0F, 3'b001, 1'b0, 1'b1, 16'hA5A5};
    tbl[12] = '{3'b001, 16'hA5A5, 16'h0F0F, 3'b001, 1'b0, 1'b1, 16'hA5A5};
    tbl[13] = '{3'b000, 16'hA5A5, 16'h0F0F, 3'b000, 1'b1, 1'b0, 16'hA5A5};

    // Single request, data follow, release to idle, then early release of src0.
    do_reset(3'b000);
    for (int i = 0; i < 14; i++) begin
      req            = tbl[i].req;
      data_in[15:0]  = tbl[i].d0;
      data_in[31:16] = tbl[i].d1;
      step();
      check($sformatf("vec%0d", i), tbl[i].eg, tbl[i].eb, tbl[i].ebusy, tbl[i].ed);
    end

    // Reset held with all requests up, then full round-robin rotation.
    data_in = {16'h3333, 16'h2222, 16'h1111};
    reset_n = 1'b0;
    req     = 3'b111;
    #1;
    check("reset_async", 3'b000, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("reset_hold%0d", i), 3'b000, 1'b1, 1'b0, 16'h0000);
    end
    reset_n = 1'b1;
    prev    = 16'h0000;
    for (int r = 0; r < 4; r++) begin
      owner = 2'(r % 3);
      word  = data_in[16*owner +: 16];
      for (int b = 0; b < 2; b++) begin
        step();
        check($sformatf("rr%0d_blank%0d", r, b), 3'b000, 1'b1, 1'b1, prev);
      end
      for (int s = 0; s < 9; s++) begin
        step();
        check($sformatf("rr%0d_show%0d", r, s), 3'b001 << owner, 1'b0, 1'b1, word);
      end
      prev = word;
    end
    step();
    check("rr_final_blank", 3'b000, 1'b1, 1'b1, prev);

    // Sole owner src2 is never dropped; a late request from src0 preempts it.
    data_in = {16'hC0DE, 16'h0000, 16'hBEEF};
    do_reset(3'b000);
    req = 3'b100;
    step();
    check("sole_blank0", 3'b000, 1'b1, 1'b1, 16'h0000);
    step();
    check("sole_blank1", 3'b000, 1'b1, 1'b1, 16'h0000);
    for (int s = 0; s < 30; s++) begin
      step();
      check($sformatf("sole_show%0d", s), 3'b100, 1'b0, 1'b1, 16'hC0DE);
    end
    req = 3'b101;
    step();
    check("preempt_blank0", 3'b000, 1'b1, 1'b1, 16'hC0DE);
    step();
    check("preempt_blank1", 3'b000, 1'b1, 1'b1, 16'hC0DE);
    step();
    check("preempt_wrap_src0", 3'b001, 1'b0, 1'b1, 16'hBEEF);

    // Asynchronous reset in the middle of a src1 ownership.
    data_in = {16'h0000, 16'h5A5A, 16'h0000};
    do_reset(3'b010);
    step();
    step();
    step();
    check("src1_owner", 3'b010, 1'b0, 1'b1, 16'h5A5A);
    #3;
    reset_n = 1'b0;
    #1;
    check("midshow_reset", 3'b000, 1'b1, 1'b0, 16'h0000);
    #2;
    reset_n = 1'b1;
    step();
    check("post_reset_blank0", 3'b000, 1'b1, 1'b1, 16'h0000);
    step();
    check("post_reset_blank1", 3'b000, 1'b1, 1'b1, 16'h0000);
    step();
    check("post_reset_src1", 3'b010, 1'b0, 1'b1, 16'h5A5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Time-shares the single 4-digit 7-segment display among N_SRC requesters, such as keypad entry, computed result and error/status code.
- Each requester raises req and presents a 16-bit hex word. The scheduler grants one owner at a time and inserts a blanking gap between owners.
- Owners are rotated round-robin after a minimum hold time.
- data_out drives the display refresh block's 16-bit hex input. blank_out gates its anodes off.

Parameters:
- N_SRC, 3: number of requesters (2..8).
- HOLD_CYCLES, 27_000_000: minimum owner display time before preemption (1 s at 27 MHz); must be >= 1.
- BLANK_CYCLES, 270_000: blank gap between owners (10 ms); must be >= 1.

Ports:
- clk  in  1  system clock (27 MHz)
- reset_n  in  1  asynchronous, active-low reset
- req  in  N_SRC  per-source display request, level-sensitive
- data_in  in  16*N_SRC  source i word at [16*i+15:16*i], digit D1 in the MSB nibble
- grant  out  N_SRC  one-hot owner indication, all-zero when no owner
- data_out  out  16  hex word to the display refresh block
- blank_out  out  1  1 = display must be dark
- busy  out  1  1 when state != IDLE

Behaviour:
- Reset (async, takes effect immediately, also mid-operation):
  - state=IDLE, grant=0, data_out=16'h0000, blank_out=1, busy=0.
  - Hold and blank counters=0, last=N_SRC-1, so source 0 wins first.
- All outputs are registered. Counter widths are $clog2(param+1), and counters never wrap.
- IDLE:
  - blank_out=1, grant=0, data_out holds its last value.
  - If |req is high at an edge, go to BLANK with blank_cnt=0.
- BLANK:
  - blank_out=1, grant=0, blank_cnt increments each cycle.
  - On the cycle where blank_cnt==BLANK_CYCLES-1, arbitrate using req sampled that cycle.
  - Winner = first set bit searching last+1, last+2, ... modulo N_SRC.
  - If a winner exists, on the next edge: state=SHOW, sel=winner, grant=onehot(winner), data_out=data_in[winner], blank_out=0, hold_cnt=0.
  - If no winner, go to IDLE.
  - A request that drops during BLANK is simply not considered.
- SHOW:
  - data_out reloads from data_in[sel] every edge, giving 1-cycle latency from data_in to data_out.
  - hold_cnt increments and saturates at HOLD_CYCLES.
- SHOW exit (evaluated each cycle, first match wins):
  - req[sel]==0: release. Next edge grant=0, blank_out=1, last=sel. Go to BLANK if any other req is high, else IDLE. Early release is allowed before the hold expires.
  - hold_cnt==HOLD_CYCLES and any other req[j] (j!=sel) is high: preempt. Next edge go to BLANK, grant=0, blank_out=1, last=sel.
  - Otherwise stay in SHOW. A sole requester keeps the display indefinitely.
- grant is never multi-hot. grant and blank_out=0 are asserted together and cleared together.
- busy=1 in BLANK and SHOW.

Test Plan (N_SRC=3, HOLD_CYCLES=8, BLANK_CYCLES=2):
1. Reset:
   - Assert reset_n=0 with req=3'b111 -> grant=0, data_out=16'h0000, blank_out=1, busy=0, held for the whole reset.
   - Release reset_n -> BLANK entered on the next edge.
2. Single request:
   - Stimulus: req=3'b010, data_in[1]=16'h12AB at cycle 0.
   - Response: BLANK at cycles 1-2. From cycle 3: grant=3'b010, blank_out=0, data_out=16'h12AB.
   - Change data_in[1] to 16'h0F0F at cycle 5 -> data_out=16'h0F0F from cycle 6.
3. Round-robin:
   - Stimulus: req=3'b111 held.
   - Response: grant sequence 001, 010, 100, 001.
   - Each owner is shown exactly 9 cycles (hold_cnt 0..8).
   - Owners are separated by 2 blank cycles with grant=0 and blank_out=1.
4. Early release:
   - Stimulus: src0 owner, req drops to 3'b000 in the 3rd SHOW cycle.
   - Response: next edge grant=0, blank_out=1, state IDLE, busy=0, data_out retains its last value.
5. Sole-owner hold and late preemption:
   - Stimulus: src2 alone for 30 cycles, then req[0] rises.
   - Response: src2 is never dropped before req[0] rises.
   - Next edge: BLANK, grant=0.
   - After 2 cycles: grant=3'b001, because last=2 and the search wraps to 0.
6. Reset mid-SHOW:
   - Stimulus: reset_n pulsed low mid-cycle during src1 ownership.
   - Response: grant=0 and blank_out=1 immediately (asynchronous).
   - After release with req=3'b010: src1 is granted again after 2 blank cycles (last reset to 2, search reaches 1 since req[0]=0).
